// File: rtl/audio_min_max_stream.sv
`default_nettype none
// ============================================================================
// Module   : audio_min_max_stream
// Purpose  : Streaming, multi-channel min/max tracker for interleaved signed
//            PCM samples. A window of 2^WINDOW_LOG2 frames is accepted over a
//            valid/ready handshake, and the per-channel minimum and maximum
//            seen in that window are published together with a one-cycle done
//            pulse.
//
// Parameters:
//   DATA_W      - sample width in bits (two's-complement signed)
//   NUM_CH      - number of interleaved channels (1..16)
//   WINDOW_LOG2 - log2 of frames per window (0..20)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   start      in   pulse, begins a window when idle
//   abort      in   pulse, cancels a running window (beats a same-cycle accept)
//   in_data    in   sample, channel order 0..NUM_CH-1 repeating
//   in_valid   in   in_data valid
//   in_ready   out  sample accepted this cycle when in_valid is also high
//   busy       out  window in progress (RUN or DONE)
//   d          out  one-cycle pulse, results updated
//   out_min    out  per-channel minimum, channel c at [c*DATA_W +: DATA_W]
//   out_max    out  per-channel maximum, same packing
//   frame_cnt  out  frames accepted in the current window
//   out_peak   out  (AUD_MINMAX_PEAK_EN only) per-channel max(|max|,|min|),
//                   |most-negative| saturated to most-positive
//
// Build option: define AUD_MINMAX_PEAK_EN to add the out_peak output.
//
// Revision : 1.0 - initial release
// ============================================================================
module audio_min_max_stream #(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 2,
  parameter int WINDOW_LOG2 = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       busy,
  output logic                       d,
  output logic [NUM_CH*DATA_W-1:0]   out_min,
  output logic [NUM_CH*DATA_W-1:0]   out_max,
  output logic [WINDOW_LOG2:0]       frame_cnt
`ifdef AUD_MINMAX_PEAK_EN
  ,
  output logic [NUM_CH*DATA_W-1:0]   out_peak
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // A single channel still needs a one-bit index register.
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [DATA_W-1:0] c_MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] c_MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  localparam int c_LAST_CH_INT    = NUM_CH - 1;
  localparam int c_LAST_FRAME_INT = (1 << WINDOW_LOG2) - 1;
  localparam int c_ONE_INT        = 1;

  localparam logic [CH_W-1:0]      c_LAST_CH    = c_LAST_CH_INT[CH_W-1:0];
  localparam logic [CH_W-1:0]      c_CH_ONE     = c_ONE_INT[CH_W-1:0];
  localparam logic [WINDOW_LOG2:0] c_LAST_FRAME = c_LAST_FRAME_INT[WINDOW_LOG2:0];
  localparam logic [WINDOW_LOG2:0] c_FRAME_ONE  = c_ONE_INT[WINDOW_LOG2:0];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]                state_q,     state_d;
  logic [CH_W-1:0]           ch_idx_q,    ch_idx_d;
  logic [WINDOW_LOG2:0]      frame_cnt_q, frame_cnt_d;
  logic [NUM_CH*DATA_W-1:0]  run_min_q,   run_min_d;
  logic [NUM_CH*DATA_W-1:0]  run_max_q,   run_max_d;
  logic [NUM_CH*DATA_W-1:0]  out_min_q;
  logic [NUM_CH*DATA_W-1:0]  out_max_q;

  // Running min/max with the current sample folded into its channel.
  logic [NUM_CH*DATA_W-1:0]  w_min_upd;
  logic [NUM_CH*DATA_W-1:0]  w_max_upd;
  logic                      w_load_out;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic w_sel;
      assign w_sel = (ch_idx_q == CH_W'(c));

      // Strict compares: equal samples leave the running value unchanged.
      assign w_min_upd[c*DATA_W +: DATA_W] =
        (w_sel && ($signed(in_data) < $signed(run_min_q[c*DATA_W +: DATA_W])))
          ? in_data : run_min_q[c*DATA_W +: DATA_W];

      assign w_max_upd[c*DATA_W +: DATA_W] =
        (w_sel && ($signed(in_data) > $signed(run_max_q[c*DATA_W +: DATA_W])))
          ? in_data : run_max_q[c*DATA_W +: DATA_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    frame_cnt_d = frame_cnt_q;
    run_min_d   = run_min_q;
    run_max_d   = run_max_q;
    w_load_out  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          run_min_d   = {NUM_CH{c_MOST_POS}};
          run_max_d   = {NUM_CH{c_MOST_NEG}};
          ch_idx_d    = '0;
          frame_cnt_d = '0;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (abort) begin
          // A sample offered in the abort cycle is dropped.
          state_d = ST_IDLE;
        end else if (in_valid) begin
          run_min_d = w_min_upd;
          run_max_d = w_max_upd;
          if (ch_idx_q == c_LAST_CH) begin
            ch_idx_d    = '0;
            frame_cnt_d = frame_cnt_q + c_FRAME_ONE;
            if (frame_cnt_q == c_LAST_FRAME) begin
              // Publish on the same edge so results are already valid while
              // d is high in the DONE cycle.
              state_d    = ST_DONE;
              w_load_out = 1'b1;
            end
          end else begin
            ch_idx_d = ch_idx_q + c_CH_ONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ch_idx_q    <= '0;
      frame_cnt_q <= '0;
      run_min_q   <= '0;
      run_max_q   <= '0;
      out_min_q   <= '0;
      out_max_q   <= '0;
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      frame_cnt_q <= frame_cnt_d;
      run_min_q   <= run_min_d;
      run_max_q   <= run_max_d;
      if (w_load_out) begin
        out_min_q <= run_min_d;
        out_max_q <= run_max_d;
      end
    end
  end

`ifdef AUD_MINMAX_PEAK_EN
  // --------------------------------------------------------------------------
  // Optional peak magnitude
  // --------------------------------------------------------------------------
  logic [NUM_CH*DATA_W-1:0] w_peak;
  logic [NUM_CH*DATA_W-1:0] out_peak_q;

  // Magnitude with the most-negative code saturated to most-positive, so the
  // result always fits a non-negative signed value.
  function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v == c_MOST_NEG) begin
      r = c_MOST_POS;
    end else if (v[DATA_W-1]) begin
      r = (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_peak
      logic [DATA_W-1:0] w_abs_min;
      logic [DATA_W-1:0] w_abs_max;
      assign w_abs_min = abs_sat(run_min_d[c*DATA_W +: DATA_W]);
      assign w_abs_max = abs_sat(run_max_d[c*DATA_W +: DATA_W]);
      // Both magnitudes are non-negative, so an unsigned compare suffices.
      assign w_peak[c*DATA_W +: DATA_W] =
        (w_abs_max > w_abs_min) ? w_abs_max : w_abs_min;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_peak_q <= '0;
    end else if (w_load_out) begin
      out_peak_q <= w_peak;
    end
  end

  assign out_peak = out_peak_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign d         = (state_q == ST_DONE);
  assign out_min   = out_min_q;
  assign out_max   = out_max_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_min_max_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_min_max_stream
// Purpose  : Self-checking bench for audio_min_max_stream (3 channels,
//            4-frame windows). A driver issues windows of random / edge-value
//            samples with random valid gaps, aborts and a mid-window reset,
//            pushing the expected per-channel results into a queue. A monitor
//            on the falling edge checks d timing, pops results on each d and
//            checks that published values hold between pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_min_max_stream;

  localparam int DW    = 32;
  localparam int NCH   = 3;
  localparam int WL2   = 2;
  localparam int NSAMP = NCH * (1 << WL2);
  localparam int VW    = NCH * DW;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            abort;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic            busy;
  logic            d;
  logic [VW-1:0]   out_min;
  logic [VW-1:0]   out_max;
  logic [WL2:0]    frame_cnt;
`ifdef AUD_MINMAX_PEAK_EN
  logic [VW-1:0]   out_peak;
`endif

  audio_min_max_stream #(
    .DATA_W      (DW),
    .NUM_CH      (NCH),
    .WINDOW_LOG2 (WL2)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .d         (d),
    .out_min   (out_min),
    .out_max   (out_max),
    .frame_cnt (frame_cnt)
`ifdef AUD_MINMAX_PEAK_EN
    ,
    .out_peak  (out_peak)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [VW-1:0] mn;
    logic [VW-1:0] mx;
    logic [VW-1:0] pk;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Signed magnitude, saturating |-2^31| to 2^31-1.
  function automatic logic [DW-1:0] abs_sat(input logic signed [DW-1:0] v);
    longint a;
    a = (v < 0) ? -longint'(v) : longint'(v);
    if (a > 64'sh7FFF_FFFF) a = 64'sh7FFF_FFFF;
    return a[DW-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: checks every falling edge
  // --------------------------------------------------------------------------
  initial begin
    logic [VW-1:0] mdl_min;
    logic [VW-1:0] mdl_max;
    logic [VW-1:0] mdl_pk;
    int            acc_cnt;
    bit            exp_d;
    exp_t          e;
    logic [VW-1:0] full;
    mdl_min = '0; mdl_max = '0; mdl_pk = '0;
    acc_cnt = 0; exp_d = 1'b0;
    full = VW'(1 << WL2);
    forever begin
      @(negedge clk);
      if (!reset) begin
        acc_cnt = 0;
        exp_d   = 1'b0;
        mdl_min = '0; mdl_max = '0; mdl_pk = '0;
        chk("reset_out_min", out_min, '0);
        chk("reset_out_max", out_max, '0);
        chk("reset_d", VW'(d), '0);
      end else begin
        chk("d_timing", VW'(d), VW'(exp_d));
        if (d) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_d actual=pulse required=none");
          end else begin
            e = exp_q.pop_front();
            mdl_min = e.mn;
            mdl_max = e.mx;
            mdl_pk  = e.pk;
          end
          chk("frame_cnt_at_d", VW'(frame_cnt), full);
        end
        chk("out_min", out_min, mdl_min);
        chk("out_max", out_max, mdl_max);
`ifdef AUD_MINMAX_PEAK_EN
        chk("out_peak", out_peak, mdl_pk);
`endif
        // Predict what the next falling edge should show.
        exp_d = 1'b0;
        if (start && !busy) begin
          acc_cnt = 0;
        end else if (in_ready && abort) begin
          acc_cnt = 0;
        end else if (in_ready && in_valid) begin
          acc_cnt++;
          if (acc_cnt == NSAMP) begin
            exp_d   = 1'b1;
            acc_cnt = 0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver helpers (all called at posedge + 1)
  // --------------------------------------------------------------------------
  function automatic logic [DW-1:0] pick();
    case ($urandom_range(7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] v, input int gap_pct);
    int n;
    bit got;
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = v;
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_ready required=ready");
    end
  endtask

  // mode 0: random/edge values, 1: all equal, 2: alternating extremes
  task automatic run_window(input int gap_pct, input int mode, input bit start_in_done);
    logic [DW-1:0]        s[NSAMP];
    logic [DW-1:0]        eqv;
    logic signed [DW-1:0] mn;
    logic signed [DW-1:0] mx;
    exp_t                 e;
    eqv = $urandom;
    for (int i = 0; i < NSAMP; i++) begin
      case (mode)
        1:       s[i] = eqv;
        2:       s[i] = (i % 2 == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        default: s[i] = pick();
      endcase
    end
    for (int c = 0; c < NCH; c++) begin
      mn = 32'sh7FFF_FFFF;
      mx = -32'sh7FFF_FFFF - 1;
      for (int i = c; i < NSAMP; i += NCH) begin
        if ($signed(s[i]) < mn) mn = $signed(s[i]);
        if ($signed(s[i]) > mx) mx = $signed(s[i]);
      end
      e.mn[c*DW +: DW] = mn;
      e.mx[c*DW +: DW] = mx;
      e.pk[c*DW +: DW] = (abs_sat(mx) > abs_sat(mn)) ? abs_sat(mx) : abs_sat(mn);
    end
    exp_q.push_back(e);

    pulse_start();
    @(negedge clk);
    chk("run_in_ready", VW'(in_ready), VW'(1));
    chk("run_busy", VW'(busy), VW'(1));
    chk("run_frame_cnt_start", VW'(frame_cnt), '0);
    @(posedge clk); #1;
    for (int i = 0; i < NSAMP; i++) send(s[i], gap_pct);
    // Now in the DONE cycle.
    chk("done_in_ready", VW'(in_ready), '0);
    chk("done_busy", VW'(busy), VW'(1));
    if (start_in_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    chk("idle_busy", VW'(busy), '0);
    chk("idle_in_ready", VW'(in_ready), '0);
    @(posedge clk); #1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", VW'(in_ready), '0);
    chk("reset_busy", VW'(busy), '0);
    chk("reset_frame_cnt", VW'(frame_cnt), '0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_window(0, 1, 1'b0);
    run_window(0, 2, 1'b0);
    run_window(50, 0, 1'b0);

    // Abort after two samples; the abort-cycle sample must be dropped.
    pulse_start();
    send(32'h0000_0005, 0);
    send(32'hFFFF_FFFD, 0);
    chk("abort_frame_cnt_mid", VW'(frame_cnt), '0);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h8000_0000;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", VW'(busy), '0);
    chk("abort_in_ready", VW'(in_ready), '0);
    repeat (2) @(posedge clk);
    #1;
    run_window(0, 0, 1'b0);

    // Reset in the middle of a window.
    pulse_start();
    for (int i = 0; i < NCH + 1; i++) send(pick(), 0);
    chk("frame_cnt_mid", VW'(frame_cnt), VW'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("async_in_ready", VW'(in_ready), '0);
    chk("async_busy", VW'(busy), '0);
    chk("async_frame_cnt", VW'(frame_cnt), '0);
    chk("async_out_min", out_min, '0);
    chk("async_out_max", out_max, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_window(50, 0, 1'b1);

    for (int w = 0; w < 6; w++) begin
      run_window($urandom_range(60), 0, w[0]);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("pending_results", VW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
